// File: rtl/vga_sync_generator.sv
// VGA raster timing: free-running h/v counters with registered sync, blank and coordinates.
// Define CLK_DIV2_EN when clk runs at twice the pixel rate.
module vga_sync_generator #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic [8:0] row,
  output logic [9:0] column,
  output logic       frame_tick
);

  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SBEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SEND = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SBEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SEND = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic       pix_en;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       blank_n_q, blank_n_d;
  logic [8:0] row_q, row_d;
  logic [9:0] column_q, column_d;
  logic       tick_q, tick_d;

`ifdef CLK_DIV2_EN
  logic pix_en_q;

  // First enabled edge is the second clk after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pix_en_q <= 1'b0;
    else      pix_en_q <= ~pix_en_q;
  end

  assign pix_en = pix_en_q;
`else
  assign pix_en = 1'b1;
`endif

  always_comb begin
    h_cnt_d = (h_cnt_q == H_LAST) ? 10'd0 : h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
    end
  end

  always_comb begin
    blank_n_d = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    column_d  = blank_n_d ? h_cnt_q : 10'd0;
    row_d     = blank_n_d ? v_cnt_q[8:0] : 9'd0;
    hsync_d   = !((h_cnt_q >= H_SBEG) && (h_cnt_q < H_SEND));
    vsync_d   = !((v_cnt_q >= V_SBEG) && (v_cnt_q < V_SEND));
    tick_d    = (h_cnt_q == 10'd0) && (v_cnt_q == V_ACT);
  end

  // Outputs register the decode of the current count, so they trail it by one pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      blank_n_q <= 1'b0;
      row_q     <= '0;
      column_q  <= '0;
      tick_q    <= 1'b0;
    end else if (pix_en) begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      blank_n_q <= blank_n_d;
      row_q     <= row_d;
      column_q  <= column_d;
      tick_q    <= tick_d;
    end else begin
      tick_q    <= 1'b0;
    end
  end

  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign blank_n    = blank_n_q;
  assign row        = row_q;
  assign column     = column_q;
  assign frame_tick = tick_q;

endmodule
